// File: rtl/cdr_phase_tracker.sv
// Oversampling CDR: bang-bang phase detector, saturating loop filter and digital
// sample-phase selector. Recovers bits at phase + OVERSAMPLE/2 and reports lock.
module cdr_phase_tracker #(
    parameter int unsigned OVERSAMPLE  = 8,
    parameter int unsigned FILTER_BITS = 3,
    parameter int unsigned LOCK_COUNT  = 16,
    localparam int unsigned PW         = $clog2(OVERSAMPLE)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          serial_in,
    output logic          data_out,
    output logic          data_valid,
    output logic          up,
    output logic          down,
    output logic [PW-1:0] phase,
    output logic          locked
);

    localparam logic [PW-1:0] Half    = PW'(OVERSAMPLE / 2);
    localparam logic [7:0]    LockMax = 8'(LOCK_COUNT);
    localparam int            Thresh  = 1 << (FILTER_BITS - 1);

    logic                          s1_q, s1_d;
    logic                          s2_q, s2_d;
    logic [PW-1:0]                 cnt_q, cnt_d;
    logic [PW-1:0]                 phase_q, phase_d;
    logic signed [FILTER_BITS-1:0] acc_q, acc_d;
    logic [7:0]                    lc_q, lc_d;
    logic                          dout_q, dout_d;
    logic                          dv_q, dv_d;
    logic                          up_q, up_d;
    logic                          down_q, down_d;

    logic          edge_det;
    logic [PW-1:0] err;
    logic [PW-1:0] sample_pt;
    logic          e_zero, e_neg, e_pos, in_window;
    int            acc_sum;

    assign edge_det  = s1_q != s2_q;
    assign err       = cnt_q - phase_q;
    assign sample_pt = phase_q + Half;
    // Sign bit set covers the exact-opposite case (-OVERSAMPLE/2), which counts as early.
    assign e_zero    = err == '0;
    assign e_neg     = err[PW-1];
    assign e_pos     = !e_neg && !e_zero;
    assign in_window = e_zero || (err == PW'(1)) || (err == '1);

    always_comb begin
        s1_d    = s1_q;
        s2_d    = s2_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        acc_d   = acc_q;
        lc_d    = lc_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        up_d    = 1'b0;
        down_d  = 1'b0;
        acc_sum = 0;
        if (enable) begin
            s1_d  = serial_in;
            s2_d  = s1_q;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == sample_pt) begin
                dv_d   = 1'b1;
                dout_d = s1_q;
            end
            if (edge_det) begin
                up_d   = e_pos;
                down_d = e_neg;
                if (in_window) begin
                    lc_d = (lc_q >= LockMax) ? lc_q : lc_q + 1'b1;
                end else begin
                    lc_d = '0;
                end
                if (e_pos) begin
                    acc_sum = int'(acc_q) + 1;
                    if (acc_sum == Thresh) begin
                        phase_d = phase_q + 1'b1;
                        acc_d   = '0;
                    end else begin
                        acc_d = FILTER_BITS'(acc_sum);
                    end
                end else if (e_neg) begin
                    acc_sum = int'(acc_q) - 1;
                    if (acc_sum == -Thresh) begin
                        phase_d = phase_q - 1'b1;
                        acc_d   = '0;
                    end else begin
                        acc_d = FILTER_BITS'(acc_sum);
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            phase_q <= '0;
            acc_q   <= '0;
            lc_q    <= '0;
            dout_q  <= 1'b0;
            dv_q    <= 1'b0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            acc_q   <= acc_d;
            lc_q    <= lc_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            up_q    <= up_d;
            down_q  <= down_d;
        end
    end

    assign data_out   = dout_q;
    assign data_valid = dv_q;
    assign up         = up_q;
    assign down       = down_q;
    assign phase      = phase_q;
    assign locked     = lc_q == LockMax;

endmodule

// File: tb/tb_cdr_phase_tracker.sv
// Directed bench for cdr_phase_tracker (8x, 3-bit filter, lock after 16 edges).
// Edges are placed at a chosen counter value using a bench-side counter.
module tb_cdr_phase_tracker;

    localparam int OS = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       serial_in = 1'b0;
    logic       data_out, data_valid, up, down, locked;
    logic [2:0] phase;

    int   checks = 0;
    int   fails = 0;
    int   tcnt = 0;
    int   dv_count = 0;
    logic last_dout = 1'b0;

    cdr_phase_tracker #(
        .OVERSAMPLE (8),
        .FILTER_BITS(3),
        .LOCK_COUNT (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .serial_in (serial_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .up        (up),
        .down      (down),
        .phase     (phase),
        .locked    (locked)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1);
    end

    // One clock; afterwards tcnt equals the DUT's counter for the current cycle.
    task automatic cycle();
        @(posedge clock);
        #1;
        if (reset) tcnt = 0;
        else if (enable) tcnt = (tcnt + 1) % OS;
        if (data_valid) begin
            dv_count++;
            last_dout = data_out;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b1;
        serial_in = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    // Toggle serial_in so the edge is evaluated in the cycle with cnt == c,
    // then return one cycle later when up/down/phase/locked reflect it.
    task automatic send_edge(input int c);
        int guard = 0;
        while (tcnt != (c + OS - 1) % OS && guard < 2 * OS) begin
            cycle();
            guard++;
        end
        serial_in = ~serial_in;
        cycle();
        cycle();
    endtask

    task automatic test_reset();
        do_reset();
        repeat (40) begin
            serial_in = 1'($urandom_range(0, 1));
            cycle();
        end
        reset = 1'b1;
        serial_in = 1'b0;
        cycle();
        if (up !== 1'b0 || down !== 1'b0) begin
            fails++; $display("FAIL reset_pulse got up=%b down=%b exp 0 0", up, down);
        end
        checks++;
        cycle();
        reset = 1'b0;
        if (data_out !== 1'b0) begin fails++; $display("FAIL reset_dout got %b exp 0", data_out); end
        checks++;
        if (data_valid !== 1'b0) begin fails++; $display("FAIL reset_dv got %b exp 0", data_valid); end
        checks++;
        if (up !== 1'b0) begin fails++; $display("FAIL reset_up got %b exp 0", up); end
        checks++;
        if (down !== 1'b0) begin fails++; $display("FAIL reset_down got %b exp 0", down); end
        checks++;
        if (phase !== 3'd0) begin fails++; $display("FAIL reset_phase got %0d exp 0", phase); end
        checks++;
        if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked got %b exp 0", locked); end
        checks++;
        for (int i = 1; i <= 5; i++) begin
            cycle();
            if (data_valid !== 1'(i == 5)) begin
                fails++; $display("FAIL reset_first_dv i=%0d got %b exp %b", i, data_valid, i == 5);
            end
            checks++;
        end
        if (data_out !== 1'b0) begin fails++; $display("FAIL reset_first_bit got %b exp 0", data_out); end
        checks++;
    endtask

    task automatic test_aligned();
        logic prev;
        int   dv0;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            prev = serial_in;
            dv0 = dv_count;
            send_edge(0);
            if (up !== 1'b0 || down !== 1'b0) begin
                fails++; $display("FAIL aligned_updown k=%0d got %b%b exp 00", k, up, down);
            end
            checks++;
            if (phase !== 3'd0) begin fails++; $display("FAIL aligned_phase k=%0d got %0d exp 0", k, phase); end
            checks++;
            if (locked !== 1'(k >= 16)) begin
                fails++; $display("FAIL aligned_locked k=%0d got %b exp %b", k, locked, k >= 16);
            end
            checks++;
            if (dv_count - dv0 != 1) begin
                fails++; $display("FAIL aligned_dv_count k=%0d got %0d exp 1", k, dv_count - dv0);
            end
            checks++;
            if (last_dout !== prev) begin
                fails++; $display("FAIL aligned_data k=%0d got %b exp %b", k, last_dout, prev);
            end
            checks++;
        end
    endtask

    task automatic test_late();
        logic [2:0] exp_ph;
        do_reset();
        for (int k = 1; k <= 26; k++) begin
            send_edge(3);
            exp_ph = (k < 4) ? 3'd0 : (k < 8) ? 3'd1 : (k < 12) ? 3'd2 : 3'd3;
            if (up !== 1'(k <= 12)) begin fails++; $display("FAIL late_up k=%0d got %b exp %b", k, up, k <= 12); end
            checks++;
            if (down !== 1'b0) begin fails++; $display("FAIL late_down k=%0d got %b exp 0", k, down); end
            checks++;
            if (phase !== exp_ph) begin fails++; $display("FAIL late_phase k=%0d got %0d exp %0d", k, phase, exp_ph); end
            checks++;
            if (locked !== 1'(k >= 24)) begin
                fails++; $display("FAIL late_locked k=%0d got %b exp %b", k, locked, k >= 24);
            end
            checks++;
        end
    endtask

    task automatic test_early();
        logic [2:0] exp_ph;
        do_reset();
        for (int k = 1; k <= 22; k++) begin
            send_edge(6);
            exp_ph = (k < 4) ? 3'd0 : (k < 8) ? 3'd7 : 3'd6;
            if (down !== 1'(k <= 8)) begin fails++; $display("FAIL early_down k=%0d got %b exp %b", k, down, k <= 8); end
            checks++;
            if (up !== 1'b0) begin fails++; $display("FAIL early_up k=%0d got %b exp 0", k, up); end
            checks++;
            if (phase !== exp_ph) begin fails++; $display("FAIL early_phase k=%0d got %0d exp %0d", k, phase, exp_ph); end
            checks++;
            if (locked !== 1'(k >= 20)) begin
                fails++; $display("FAIL early_locked k=%0d got %b exp %b", k, locked, k >= 20);
            end
            checks++;
        end
    endtask

    task automatic test_opposite();
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            send_edge(4);
            if (up !== 1'b0 || down !== 1'b1) begin
                fails++; $display("FAIL opp_dir k=%0d got up=%b down=%b exp 0 1", k, up, down);
            end
            checks++;
            if (phase !== ((k == 4) ? 3'd7 : 3'd0)) begin
                fails++; $display("FAIL opp_phase k=%0d got %0d exp %0d", k, phase, (k == 4) ? 7 : 0);
            end
            checks++;
        end
        for (int k = 1; k <= 16; k++) begin
            send_edge(7);
            if (up !== 1'b0 || down !== 1'b0) begin
                fails++; $display("FAIL opp_relock_updown k=%0d got %b%b exp 00", k, up, down);
            end
            checks++;
            if (k >= 15 && locked !== 1'(k == 16)) begin
                fails++; $display("FAIL opp_relock k=%0d got %b exp %b", k, locked, k == 16);
            end
            checks++;
        end
        send_edge(3);
        if (down !== 1'b1 || up !== 1'b0) begin
            fails++; $display("FAIL opp_drop_dir got up=%b down=%b exp 0 1", up, down);
        end
        checks++;
        if (locked !== 1'b0) begin fails++; $display("FAIL opp_drop_locked got %b exp 0", locked); end
        checks++;
        if (phase !== 3'd7) begin fails++; $display("FAIL opp_drop_phase got %0d exp 7", phase); end
        checks++;
    endtask

    task automatic test_enable();
        logic hold;
        do_reset();
        for (int k = 1; k <= 16; k++) send_edge(0);
        while (tcnt != 4) cycle();
        hold = data_out;
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5 || i == 10) serial_in = ~serial_in;
            cycle();
            if (up !== 1'b0 || down !== 1'b0 || data_valid !== 1'b0) begin
                fails++;
                $display("FAIL freeze_strobes i=%0d got up=%b down=%b dv=%b exp 0 0 0",
                         i, up, down, data_valid);
            end
            checks++;
            if (phase !== 3'd0) begin fails++; $display("FAIL freeze_phase i=%0d got %0d exp 0", i, phase); end
            checks++;
            if (locked !== 1'b1) begin fails++; $display("FAIL freeze_locked i=%0d got %b exp 1", i, locked); end
            checks++;
            if (data_out !== hold) begin
                fails++; $display("FAIL freeze_dout i=%0d got %b exp %b", i, data_out, hold);
            end
            checks++;
        end
        enable = 1'b1;
        cycle();
        if (data_valid !== 1'b1) begin fails++; $display("FAIL resume_dv got %b exp 1", data_valid); end
        checks++;
        if (data_out !== serial_in) begin
            fails++; $display("FAIL resume_dout got %b exp %b", data_out, serial_in);
        end
        checks++;
        for (int k = 1; k <= 2; k++) begin
            send_edge(0);
            if (up !== 1'b0 || down !== 1'b0 || locked !== 1'b1) begin
                fails++;
                $display("FAIL resume_track k=%0d got up=%b down=%b locked=%b exp 0 0 1",
                         k, up, down, locked);
            end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_late();
        test_early();
        test_opposite();
        test_enable();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
